pri_scan: RTL

PRI_SCAN -- requirements
Module: pri_scan

---
 rtl/pri_scan.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pri_scan.sv
// Priority scanner: emits the set bits of a captured vector as one-hot beats in priority order.
// Optional binary index output idx_o is enabled by defining PRI_SCAN_IDX_EN.
module pri_scan #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned GROUP     = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             next_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
`ifdef PRI_SCAN_IDX_EN
  output logic [$clog2(WIDTH)-1:0] idx_o,
`endif
  output logic             done_o
);

  localparam int unsigned NG = WIDTH / GROUP;
  localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned BW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  src;
  logic [NG-1:0]     grp_hit;
  logic [GW-1:0]     grp_idx;
  logic [IW-1:0]     base;
  logic [GROUP-1:0]  grp_bits;
  logic [BW-1:0]     bit_idx;
  logic [IW-1:0]     sel_idx;
  logic [WIDTH-1:0]  pick;
  logic              last_c;
  int                gi;
  int                bi;

  // Two-level tree over the incoming vector (IDLE) or the remainder minus the current beat (SCAN).
  // Iterating from lowest to highest priority lets the last hit win.
  always_comb begin
    src = (state_q == IDLE) ? data_i : (rem_q & ~data_o);
    gi  = 0;
    bi  = 0;
    for (int g = 0; g < int'(NG); g++) begin
      grp_hit[g] = |src[g*GROUP +: GROUP];
    end
    grp_idx = '0;
    for (int g = 0; g < int'(NG); g++) begin
      gi = (MSB_FIRST != 0) ? g : int'(NG) - 1 - g;
      if (grp_hit[gi]) grp_idx = GW'(gi);
    end
    base     = IW'(grp_idx) * IW'(GROUP);
    grp_bits = src[base +: GROUP];
    bit_idx  = '0;
    for (int b = 0; b < int'(GROUP); b++) begin
      bi = (MSB_FIRST != 0) ? b : int'(GROUP) - 1 - b;
      if (grp_bits[bi]) bit_idx = BW'(bi);
    end
    sel_idx       = base + IW'(bit_idx);
    pick          = '0;
    pick[sel_idx] = |src;
    last_c        = ~|(src & ~pick);
  end

  // Abort and reset share the same flush: everything cleared, no completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      done_o  <= 1'b0;
`ifdef PRI_SCAN_IDX_EN
      idx_o   <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (state_q == IDLE) begin
        if (init_i) begin
          rem_q <= data_i;
          if (|data_i) begin
            state_q <= SCAN;
            busy_o  <= 1'b1;
            valid_o <= 1'b1;
            data_o  <= pick;
            last_o  <= last_c;
`ifdef PRI_SCAN_IDX_EN
            idx_o   <= sel_idx;
`endif
          end else begin
            done_o <= 1'b1;
          end
        end
      end else if (next_i) begin
        if (last_o) begin
          state_q <= IDLE;
          rem_q   <= '0;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
          data_o  <= '0;
          last_o  <= 1'b0;
          done_o  <= 1'b1;
`ifdef PRI_SCAN_IDX_EN
          idx_o   <= '0;
`endif
        end else begin
          rem_q  <= src;
          data_o <= pick;
          last_o <= last_c;
`ifdef PRI_SCAN_IDX_EN
          idx_o  <= sel_idx;
`endif
        end
      end
    end
  end

endmodule
